// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad lines and key-code FIFO handshake for keypad_scanner
interface keypad_scanner_if;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       overflow_clr;
  logic       irq;
  modport master (
    input  keypad_row, key_ready, overflow_clr,
    output keypad_col, key_valid, key_code, key_held, overflow, irq
  );
  modport slave (
    output keypad_row, key_ready, overflow_clr,
    input  keypad_col, key_valid, key_code, key_held, overflow, irq
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with press/release debounce and a key-code FIFO
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input logic               axi_aclk,
  input logic               axi_aresetn,
  keypad_scanner_if.master  bus
);
  localparam int MAXC = SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  // code for (row, col) at nibble {row, col}
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;
  typedef enum logic [1:0] {S_SCAN, S_DEB_PRESS, S_HELD, S_DEB_REL} state_t;
  state_t        r_state, w_state_nx;
  logic [3:0]    r_sync1, r_rs, r_lat_row;
  logic [1:0]    r_col, w_col_nx, w_row;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic          w_latch, w_push;
  logic [3:0]    w_code;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr, r_rd;
  logic          r_ovf;
  logic          w_empty, w_full, w_pop, w_wr_en, w_drop;
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_sync1 <= 4'hF;
      r_rs    <= 4'hF;
    end else begin
      r_sync1 <= bus.keypad_row;
      r_rs    <= r_sync1;
    end
  end
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_cnt_inc;
    w_col_nx   = r_col;
    w_latch    = 1'b0;
    w_push     = 1'b0;
    unique case (r_state)
      S_SCAN: begin
        if (r_rs != 4'hF) begin
          w_state_nx = S_DEB_PRESS;
          w_cnt_nx   = CW'(1);
          w_latch    = 1'b1;
        end else if (r_cnt >= SCAN_LAST) begin
          w_cnt_nx = '0;
          w_col_nx = r_col + 2'd1;
        end
      end
      S_DEB_PRESS: begin
        if (r_rs != r_lat_row) begin
          w_state_nx = S_SCAN;
          w_cnt_nx   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nx = S_HELD;
          w_cnt_nx   = '0;
          w_push     = 1'b1;
        end
      end
      S_HELD: begin
        w_cnt_nx = '0;
        if (r_rs == 4'hF) begin
          w_state_nx = S_DEB_REL;
          w_cnt_nx   = CW'(1);
        end
      end
      S_DEB_REL: begin
        if (r_rs != 4'hF) begin
          w_state_nx = S_HELD;
          w_cnt_nx   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nx = S_SCAN;
          w_cnt_nx   = '0;
          w_col_nx   = r_col + 2'd1;
        end
      end
      default: w_state_nx = S_SCAN;
    endcase
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state   <= S_SCAN;
      r_cnt     <= '0;
      r_col     <= 2'd0;
      r_lat_row <= 4'hF;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_col     <= w_col_nx;
      r_lat_row <= w_latch ? r_rs : r_lat_row;
    end
  end
  // lowest pressed row wins when several rows read low
  assign w_row  = !r_lat_row[0] ? 2'd0 : !r_lat_row[1] ? 2'd1 : !r_lat_row[2] ? 2'd2 : 2'd3;
  assign w_code = KEYMAP[{w_row, r_col, 2'b00} +: 4];
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr - r_rd) == FULL_CNT;
  assign w_pop   = !w_empty && bus.key_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  always_ff @(posedge axi_aclk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= w_code;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wr  <= w_wr_en ? r_wr + 1'b1 : r_wr;
      r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
      r_ovf <= w_drop ? 1'b1 : bus.overflow_clr ? 1'b0 : r_ovf;
    end
  end
  assign bus.keypad_col = ~(4'b0001 << r_col);
  assign bus.key_valid  = !w_empty;
  assign bus.key_code   = w_empty ? 4'h0 : r_mem[r_rd[AW-1:0]];
  assign bus.key_held   = r_state == S_HELD || r_state == S_DEB_REL;
  assign bus.overflow   = r_ovf;
  assign bus.irq        = !w_empty;
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 1000, meaning cycles each column is driven while idle-scanning (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles the row state must be stable to accept a press or a release (minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning key-code FIFO entries (power of two).
REQ-004 SHALL have port axi_aclk, input, 1, sole clock.
REQ-005 SHALL have port axi_aresetn, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port keypad_row, input, 4, asynchronous row sense, active-low.
REQ-007 SHALL have port keypad_col, output, 4, column drive, active-low, one-cold.
REQ-008 SHALL have port key_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port key_code, output, 4, FIFO head code.
REQ-010 SHALL have port key_ready, input, 1, consumer accepts the head.
REQ-011 SHALL have port key_held, output, 1, a debounced key is currently down.
REQ-012 SHALL have port overflow, output, 1, sticky: a key was dropped.
REQ-013 SHALL have port overflow_clr, input, 1, clears overflow.
REQ-014 SHALL have port irq, output, 1, equal to key_valid.

Function
REQ-015 SHALL pass keypad_row through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-016 SHALL implement FSM states SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-017 SCAN: SHALL drive column c low (c = 0..3, keypad_col = ~(1<<c)) and advance c modulo 4 every SCAN_CYCLES cycles; if rs != 4'hF, SHALL latch c and rs, and go to DEB_PRESS with c frozen.
REQ-018 DEB_PRESS: SHALL count cycles while rs equals the latched value; on any change, SHALL return to SCAN (counter cleared, c unchanged); when the count reaches DEBOUNCE_CYCLES, SHALL go to HELD.
REQ-019 On entry to HELD, SHALL push one code for (r = lowest index with rs[r]==0, c) and SHALL assert key_held; key_held SHALL stay high through HELD and DEB_REL.
REQ-020 Key map (r,c)->code: row0 {1,2,3,A}, row1 {4,5,6,B}, row2 {7,8,9,C}, row3 {0,F,E,D}, each code being the hex value of its legend.
REQ-021 HELD: SHALL go to DEB_REL when rs == 4'hF.
REQ-022 DEB_REL: SHALL count cycles while rs == 4'hF; if rs != 4'hF, SHALL return to HELD (no new push); at DEBOUNCE_CYCLES, SHALL go to SCAN, clear key_held, and advance c.
REQ-023 FIFO: key_valid/key_code SHALL show the head; a pop SHALL occur when key_valid & key_ready; key_code SHALL be stable while key_valid & !key_ready.
REQ-024 A push when the FIFO is full SHALL drop the code and set overflow; a simultaneous push and pop when full SHALL succeed with no overflow.
REQ-025 A push into an empty FIFO SHALL raise key_valid on the next cycle (push-to-valid latency 1).
REQ-026 overflow_clr SHALL clear overflow; if it coincides with a drop, overflow SHALL remain set.
REQ-027 Counters SHALL be sized $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))+1 bits and SHALL saturate, never wrap.

Reset
REQ-028 When axi_aresetn is low at a clock edge: state=SCAN, c=0, keypad_col=4'hE, all counters=0, FIFO empty, key_valid=0, key_code=0, key_held=0, overflow=0, irq=0, synchronizer=4'hF.
REQ-029 Reset mid-debounce or mid-hold SHALL discard the pending key, with no push after reset release.

Verification (SCAN_CYCLES=8, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4)
REQ-030 Stimulus: drive row1 low while col2 is active, hold 40 cycles, then release. Required: exactly one code 4'h6, key_valid high 1 cycle after the push, and key_held falling 16 cycles after release sync.
REQ-031 Stimulus: row glitch low for 5 cycles. Required: no push, and scanning resumes from the same column.
REQ-032 Stimulus: row bounce during release (high 10 cycles, low 3, then high). Required: a single code only.
REQ-033 Stimulus: press keys 6,4,8,2,9 with key_ready=0, then assert overflow_clr. Required: FIFO holds 6,4,8,2, overflow=1 after the fifth key, then overflow=0 after the clear; with key_ready=1, pops 6,4,8,2 in order.
REQ-034 Stimulus: rows 0 and 2 both low on col0. Required: code 4'h1.
REQ-035 Stimulus: assert reset during HELD with 2 codes queued. Required: key_valid=0, keypad_col=4'hE next cycle, and no code emitted after release.
